regfile_wr_sched: RTL and testbench
===================================

# regfile_wr_sched

Write-port scheduler for the 32x32 register file in the multicycle MIPS datapath. It shares the register file's single write port between NREQ writeback requesters (e.g. ALU result, memory load) using round-robin arbitration with valid/ready handshakes. It also runs a software/debug-initiated clear sequence that zeroes all 32 registers, one per cycle. Address 0 writes from requesters are accepted and discarded, so $zero stays 0.

## Interface
- NREQ, 2, number of writeback requesters (2..4)
- AW, 5, register address width
- DW, 32, data width
- NREG, 32, registers cleared by a clear sequence (= 2**AW)

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  requester i has a write pending
- req_ready  out  NREQ  requester i accepted this cycle (one-hot or zero)
- req_addr  in  NREQ*AW  packed destination addresses; requester i at [i*AW +: AW]
- req_data  in  NREQ*DW  packed write data; requester i at [i*DW +: DW]
- clr_start  in  1  single-cycle request to zero all registers
- clr_busy  out  1  clear sequence in progress
- clr_done  out  1  one-cycle pulse after the last clear write
- rf_write  out  1  register file write enable (registered)
- rf_wrAddr  out  AW  register file write address (registered)
- rf_wrData  out  DW  register file write data (registered)

## Operation
- States: IDLE, CLEAR.
- IDLE:
  - If clr_start=1: no grant this cycle (all req_ready=0), next state CLEAR. Clear wins over simultaneous requests.
  - Otherwise, when any req_valid is set, grant exactly one requester. req_ready is combinational from req_valid and the priority pointer.
  - Round-robin order: the grant goes to the first valid requester after the last granted one, searching cyclically. After reset, last-granted = NREQ-1, so requester 0 has highest priority.
  - The priority pointer updates only on an actual grant.
- Accepted write with addr != 0: next edge loads rf_write=1, rf_wrAddr=addr, rf_wrData=data.
- Accepted write with addr == 0: the handshake completes (ready=1), pointer advances, rf_write=0 next cycle.
- No grant: next edge rf_write=0; rf_wrAddr and rf_wrData hold their values.
- CLEAR:
  - Issue writes to addresses 0..NREG-1 in order, data 0, one per cycle. Address 0 is written here.
  - All req_ready=0 and clr_start is ignored.
  - After address NREG-1 is issued, return to IDLE and pulse clr_done.
- Requesters must hold valid/addr/data stable until they see ready. The block never drops a held request except on reset.
- reset (any state, including mid-CLEAR): state=IDLE, pointer=NREQ-1, counter=0, rf_write=0, rf_wrAddr=0, rf_wrData=0, clr_busy=0, clr_done=0. A partially completed clear is abandoned, not resumed.

## Timing
- Writeback latency: handshake in cycle N → rf_write high in cycle N+1; register contents visible on read ports at N+2.
- Throughput: one accepted write per cycle; back-to-back grants are allowed.
- Clear started by clr_start in cycle N:
  - rf_write=1 in cycles N+1..N+NREG, with rf_wrAddr = 0..NREG-1.
  - clr_busy=1 in cycles N+1..N+NREG.
  - clr_done=1 in cycle N+NREG+1 only, when state is already IDLE; a grant is possible in that same cycle.
- clr_start in cycle N+NREG+1 starts a new clear immediately.
- Clear counter is AW+1 bits. Terminal condition: counter reaches NREG-1 issued; no wrap into a second pass.

## Structure
- Shared package regfile_sched_pkg:
  - state enum (IDLE, CLEAR)
  - default AW/DW/NREG constants
  - ZERO_REG address constant (0)
- Sub-module rr_arbiter (parameter N):
  - Inputs: req[N], advance.
  - Outputs: one-hot grant[N], combinational.
  - Internal last-granted pointer, updated on advance.
  - Reset to N-1.
- Top level holds the FSM, clear counter, output registers, and the address-0 filter.

## Test plan
- Single write: req_valid[0]=1, addr=5, data=0xDEADBEEF in cycle 1 → req_ready[0]=1 in cycle 1; rf_write=1, addr 5, data 0xDEADBEEF in cycle 2; rf_write=0 in cycle 3.
- Fairness: both requesters valid continuously for 6 cycles from reset → grants 0,1,0,1,0,1; requester 1 alone after that → granted every cycle.
- $zero filter: requester 1 writes addr 0, data 0x1234 → req_ready[1]=1, rf_write=0 next cycle; the next grant with both valid goes to requester 0.
- Clear precedence: clr_start=1 with req_valid=2'b11 in cycle N → no ready in cycle N; writes to addresses 0..31 with data 0 in N+1..N+32; clr_done in N+33 together with a grant to requester 0.
- Reset mid-clear: reset asserted at the 10th clear write → next cycle all outputs 0, state IDLE, no clr_done; a fresh clr_start restarts from address 0.
- Hold under stall: requester 1 valid with changing addr/data is forbidden; verify ready stays 0 throughout CLEAR and requester 1 is granted in the first IDLE cycle.

Source files
------------

// File: rtl/regfile_sched_pkg.sv
// regfile_sched_pkg: shared state type and default sizes for the register-file write scheduler
package regfile_sched_pkg;
   typedef enum logic {IDLE, CLEAR} state_t;
   localparam int DEF_AW = 5;
   localparam int DEF_DW = 32;
   localparam int DEF_NREG = 32;
   localparam logic [DEF_AW-1:0] ZERO_REG = '0;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant; search starts just after the last granted requester
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] grant
);
   localparam int LW = N > 1 ? $clog2(N) : 1;
   logic [LW-1:0] r_last, w_idx;
   // descending scan so the nearest requester after r_last is the final assignment
   always_comb begin
      w_idx = r_last;
      for (int k = N; k >= 1; k--)
         if (req[(int'(r_last) + k) % N]) w_idx = LW'((int'(r_last) + k) % N);
      grant = |req ? N'(1) << w_idx : '0;
   end
   always_ff @(posedge clk)
      if (reset) r_last <= LW'(N - 1);
      else if (advance) r_last <= w_idx;
endmodule

// File: rtl/regfile_wr_sched.sv
// regfile_wr_sched: shares the register-file write port between requesters and runs the zeroing sequence
module regfile_wr_sched
   import regfile_sched_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int AW   = DEF_AW,
   parameter int DW   = DEF_DW,
   parameter int NREG = DEF_NREG
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_data,
   input  logic               clr_start,
   output logic               clr_busy,
   output logic               clr_done,
   output logic               rf_write,
   output logic [AW-1:0]      rf_wrAddr,
   output logic [DW-1:0]      rf_wrData
);
   state_t          r_state, w_next;
   logic [AW:0]     r_cnt, w_cnt;
   logic [NREQ-1:0] w_gnt;
   logic            w_en, w_wr, w_done;
   logic [AW-1:0]   w_sel_addr, w_addr;
   logic [DW-1:0]   w_sel_data, w_data;
   assign w_en      = r_state == IDLE && !clr_start;
   assign req_ready = w_en ? w_gnt : '0;
   assign clr_busy  = r_state == CLEAR;
   rr_arbiter #(.N(NREQ)) u_arb (
      .clk    (clk),
      .reset  (reset),
      .req    (req_valid),
      .advance(w_en && |req_valid),
      .grant  (w_gnt)
   );
   always_comb begin
      w_sel_addr = '0;
      w_sel_data = '0;
      for (int i = 0; i < NREQ; i++)
         if (w_gnt[i]) begin
            w_sel_addr = req_addr[i*AW +: AW];
            w_sel_data = req_data[i*DW +: DW];
         end
   end
   // r_cnt tracks the clear address currently presented on rf_wrAddr
   always_comb begin
      w_next = r_state;
      w_cnt  = r_cnt;
      w_wr   = 1'b0;
      w_done = 1'b0;
      w_addr = rf_wrAddr;
      w_data = rf_wrData;
      if (r_state == IDLE) begin
         if (clr_start) begin
            w_next = CLEAR;
            w_cnt  = '0;
            w_wr   = 1'b1;
            w_addr = '0;
            w_data = '0;
         end else if (|req_valid && w_sel_addr != AW'(ZERO_REG)) begin
            w_wr   = 1'b1;
            w_addr = w_sel_addr;
            w_data = w_sel_data;
         end
      end else if (r_cnt == (AW+1)'(NREG - 1)) begin
         w_next = IDLE;
         w_done = 1'b1;
      end else begin
         w_cnt  = r_cnt + 1'b1;
         w_wr   = 1'b1;
         w_addr = AW'(r_cnt + 1'b1);
         w_data = '0;
      end
   end
   always_ff @(posedge clk)
      if (reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         rf_write  <= 1'b0;
         rf_wrAddr <= '0;
         rf_wrData <= '0;
         clr_done  <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_cnt     <= w_cnt;
         rf_write  <= w_wr;
         rf_wrAddr <= w_addr;
         rf_wrData <= w_data;
         clr_done  <= w_done;
      end
endmodule

// File: tb/tb_regfile_wr_sched.sv
// tb_regfile_wr_sched: directed scenarios plus randomized traffic against a queue-based reference model
module tb_regfile_wr_sched;
   localparam int NREQ = 2, AW = 5, DW = 32, NREG = 32;
   logic               clk = 1'b0, reset, clr_start, clr_busy, clr_done, rf_write;
   logic [NREQ-1:0]    req_valid, req_ready;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_data;
   logic [AW-1:0]      rf_wrAddr;
   logic [DW-1:0]      rf_wrData;
   int checks = 0, failures = 0;
   int m_last;
   bit m_busy, m_done, m_wr;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   int clrq[$];

   regfile_wr_sched #(.NREQ(NREQ), .AW(AW), .DW(DW), .NREG(NREG)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_data(req_data), .clr_start(clr_start),
      .clr_busy(clr_busy), .clr_done(clr_done), .rf_write(rf_write),
      .rf_wrAddr(rf_wrAddr), .rf_wrData(rf_wrData)
   );

   always #5 clk = ~clk;

   function automatic logic [NREQ-1:0] exp_ready();
      if (m_busy || clr_start) return '0;
      for (int k = 1; k <= NREQ; k++)
         if (req_valid[(m_last + k) % NREQ]) return NREQ'(1) << ((m_last + k) % NREQ);
      return '0;
   endfunction

   // advances the reference model by one clock using the inputs currently driven, then steps the clock
   task automatic tick();
      logic [NREQ-1:0] g;
      int gi;
      g = exp_ready();
      gi = 0;
      for (int i = 0; i < NREQ; i++) if (g[i]) gi = i;
      if (reset) begin
         m_last = NREQ - 1; m_busy = 0; m_done = 0; m_wr = 0; m_addr = '0; m_data = '0;
         clrq.delete();
      end else begin
         m_done = 0;
         if (m_busy) begin
            if (clrq.size() > 0) begin
               m_wr = 1; m_addr = AW'(clrq.pop_front()); m_data = '0;
            end else begin
               m_busy = 0; m_done = 1; m_wr = 0;
            end
         end else if (clr_start) begin
            for (int a = 1; a < NREG; a++) clrq.push_back(a);
            m_busy = 1; m_wr = 1; m_addr = '0; m_data = '0;
         end else if (g != 0) begin
            m_last = gi;
            m_wr = req_addr[gi*AW +: AW] != 0;
            if (m_wr) begin
               m_addr = req_addr[gi*AW +: AW];
               m_data = req_data[gi*DW +: DW];
            end
         end else m_wr = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1; req_valid = '0; clr_start = 0;
      tick();
      reset = 0;
   endtask

   task automatic test_reset();
      reset = 1; req_valid = '0; req_addr = '0; req_data = '0; clr_start = 0;
      tick(); tick();
      reset = 0;
      #1;
      checks++; if (rf_write !== 1'b0) begin failures++; $display("FAIL reset_wr got %b want 0", rf_write); end
      checks++; if (rf_wrAddr !== '0) begin failures++; $display("FAIL reset_addr got %0d want 0", rf_wrAddr); end
      checks++; if (rf_wrData !== '0) begin failures++; $display("FAIL reset_data got %h want 0", rf_wrData); end
      checks++; if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin failures++; $display("FAIL reset_clr got busy=%b done=%b want 0 0", clr_busy, clr_done); end
      checks++; if (req_ready !== '0) begin failures++; $display("FAIL reset_rdy got %b want 00", req_ready); end
   endtask

   task automatic test_single_write();
      req_valid = 2'b01; req_addr[0 +: AW] = 5; req_data[0 +: DW] = 32'hDEADBEEF;
      #1;
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL single_rdy got %b want 01", req_ready); end
      tick();
      req_valid = '0;
      checks++; if ({rf_write, rf_wrAddr, rf_wrData} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
         failures++; $display("FAIL single_wr got wr=%b a=%0d d=%h want 1 5 deadbeef", rf_write, rf_wrAddr, rf_wrData); end
      tick();
      checks++; if (rf_write !== 1'b0) begin failures++; $display("FAIL single_idle got %b want 0", rf_write); end
   endtask

   task automatic test_fairness();
      logic [NREQ-1:0] e;
      do_reset();
      req_valid = 2'b11; req_addr = {5'd7, 5'd3}; req_data = {32'h11111111, 32'h00000000};
      for (int c = 0; c < 6; c++) begin
         e = c % 2 == 0 ? 2'b01 : 2'b10;
         #1;
         checks++; if (req_ready !== e) begin failures++; $display("FAIL fair_rdy c=%0d got %b want %b", c, req_ready, e); end
         tick();
         checks++; if (rf_wrAddr !== (e[0] ? 5'd3 : 5'd7)) begin failures++; $display("FAIL fair_addr c=%0d got %0d want %0d", c, rf_wrAddr, e[0] ? 3 : 7); end
      end
      req_valid = 2'b10;
      for (int c = 0; c < 4; c++) begin
         #1;
         checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL solo_rdy c=%0d got %b want 10", c, req_ready); end
         tick();
      end
   endtask

   task automatic test_zero_filter();
      req_valid = 2'b10; req_addr[AW +: AW] = 0; req_data[DW +: DW] = 32'h1234;
      #1;
      checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL zero_rdy got %b want 10", req_ready); end
      tick();
      checks++; if (rf_write !== 1'b0) begin failures++; $display("FAIL zero_wr got %b want 0", rf_write); end
      req_valid = 2'b11;
      #1;
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL zero_next got %b want 01", req_ready); end
      req_valid = '0;
      tick();
   endtask

   task automatic test_clear_precedence();
      do_reset();
      req_valid = 2'b11; req_addr = {5'd6, 5'd4}; req_data = {32'hBBBB, 32'hAAAA};
      clr_start = 1;
      #1;
      checks++; if (req_ready !== '0) begin failures++; $display("FAIL clr_rdy0 got %b want 00", req_ready); end
      tick();
      clr_start = 0;
      for (int a = 0; a < NREG; a++) begin
         #1;
         checks++; if ({req_ready, rf_write, rf_wrAddr, rf_wrData, clr_busy, clr_done} !== {2'b00, 1'b1, AW'(a), 32'h0, 1'b1, 1'b0}) begin
            failures++; $display("FAIL clr_seq a=%0d got rdy=%b wr=%b a=%0d d=%h busy=%b done=%b", a, req_ready, rf_write, rf_wrAddr, rf_wrData, clr_busy, clr_done); end
         tick();
      end
      checks++; if ({clr_done, clr_busy, req_ready} !== {1'b1, 1'b0, 2'b01}) begin
         failures++; $display("FAIL clr_done got done=%b busy=%b rdy=%b want 1 0 01", clr_done, clr_busy, req_ready); end
      tick();
      req_valid = '0;
      checks++; if ({clr_done, rf_write, rf_wrAddr, rf_wrData} !== {1'b0, 1'b1, 5'd4, 32'hAAAA}) begin
         failures++; $display("FAIL clr_after got done=%b wr=%b a=%0d d=%h want 0 1 4 aaaa", clr_done, rf_write, rf_wrAddr, rf_wrData); end
   endtask

   task automatic test_reset_mid_clear();
      do_reset();
      clr_start = 1;
      tick();
      clr_start = 0;
      repeat (9) tick();
      checks++; if (rf_wrAddr !== 5'd9) begin failures++; $display("FAIL mid_addr got %0d want 9", rf_wrAddr); end
      reset = 1;
      tick();
      reset = 0;
      checks++; if ({rf_write, rf_wrAddr, rf_wrData, clr_busy, clr_done} !== '0) begin
         failures++; $display("FAIL mid_reset got wr=%b a=%0d d=%h busy=%b done=%b want all 0", rf_write, rf_wrAddr, rf_wrData, clr_busy, clr_done); end
      tick();
      checks++; if (clr_done !== 1'b0 || rf_write !== 1'b0) begin failures++; $display("FAIL mid_nodone got done=%b wr=%b want 0 0", clr_done, rf_write); end
      clr_start = 1;
      tick();
      clr_start = 0;
      checks++; if ({rf_write, rf_wrAddr, clr_busy} !== {1'b1, 5'd0, 1'b1}) begin
         failures++; $display("FAIL mid_restart got wr=%b a=%0d busy=%b want 1 0 1", rf_write, rf_wrAddr, clr_busy); end
      tick();
      checks++; if (rf_wrAddr !== 5'd1) begin failures++; $display("FAIL mid_second got %0d want 1", rf_wrAddr); end
   endtask

   task automatic test_hold_under_stall();
      do_reset();
      req_valid = 2'b10; req_addr[AW +: AW] = 9; req_data[DW +: DW] = 32'hCAFE;
      clr_start = 1;
      tick();
      clr_start = 0;
      for (int a = 0; a < NREG; a++) begin
         #1;
         checks++; if (req_ready !== '0) begin failures++; $display("FAIL stall_rdy a=%0d got %b want 00", a, req_ready); end
         tick();
      end
      #1;
      checks++; if (req_ready !== 2'b10 || clr_done !== 1'b1) begin failures++; $display("FAIL stall_grant got rdy=%b done=%b want 10 1", req_ready, clr_done); end
      tick();
      req_valid = '0;
      checks++; if ({rf_write, rf_wrAddr, rf_wrData} !== {1'b1, 5'd9, 32'hCAFE}) begin
         failures++; $display("FAIL stall_wr got wr=%b a=%0d d=%h want 1 9 cafe", rf_write, rf_wrAddr, rf_wrData); end
   endtask

   task automatic test_random();
      logic [NREQ-1:0] g;
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         reset = $urandom_range(0, 199) == 0;
         clr_start = !reset && $urandom_range(0, 59) == 0;
         for (int i = 0; i < NREQ; i++)
            if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
               req_valid[i] = 1;
               req_addr[i*AW +: AW] = $urandom_range(0, 7) == 0 ? '0 : AW'($urandom);
               req_data[i*DW +: DW] = $urandom;
            end
         #1;
         g = reset ? '0 : exp_ready();
         if (!reset) begin
            checks++; if (req_ready !== g) begin failures++; $display("FAIL rnd_rdy c=%0d got %b want %b", c, req_ready, g); end
         end
         tick();
         checks++; if ({rf_write, rf_wrAddr, rf_wrData, clr_busy, clr_done} !== {m_wr, m_addr, m_data, m_busy, m_done}) begin
            failures++; $display("FAIL rnd_out c=%0d got wr=%b a=%0d d=%h busy=%b done=%b want %b %0d %h %b %b",
               c, rf_write, rf_wrAddr, rf_wrData, clr_busy, clr_done, m_wr, m_addr, m_data, m_busy, m_done); end
         req_valid = req_valid & ~g;
      end
      reset = 0; clr_start = 0; req_valid = '0;
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_fairness();
      test_zero_filter();
      test_clear_precedence();
      test_reset_mid_clear();
      test_hold_under_stall();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
